// File: rtl/alu_result_collector.sv
// Collects one ALU unit result per cycle, tags it with its source unit and
// queues it in a small first-word-fall-through FIFO drained by valid/ready.
module alu_result_collector #(
  parameter int OUT_WIDTH_A = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int DEPTH       = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [OUT_WIDTH_A-1:0]      Arith_OUT,
  input  logic [OUT_WIDTH-1:0]        Logic_OUT,
  input  logic [OUT_WIDTH-1:0]        CMP_OUT,
  input  logic [OUT_WIDTH-1:0]        Shift_OUT,
  input  logic                        Carry_OUT,
  input  logic                        Arith_Flag,
  input  logic                        Logic_Flag,
  input  logic                        CMP_Flag,
  input  logic                        Shift_Flag,
  input  logic                        RES_READY,
  input  logic                        CLR_ERR,
  output logic                        RES_VALID,
  output logic [OUT_WIDTH_A-1:0]      RES_DATA,
  output logic [1:0]                  RES_TAG,
  output logic                        RES_CARRY,
  output logic [$clog2(DEPTH):0]      RES_COUNT,
  output logic                        ERR_OVF,
  output logic                        ERR_MULTI
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] TAG_ARITH = 2'b00;
  localparam logic [1:0] TAG_LOGIC = 2'b01;
  localparam logic [1:0] TAG_CMP   = 2'b10;
  localparam logic [1:0] TAG_SHIFT = 2'b11;

  logic [OUT_WIDTH_A-1:0] mem_data [DEPTH];
  logic [1:0]             mem_tag  [DEPTH];
  logic                   mem_carry[DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   write_en;
  logic                   drop;
  logic                   multi;
  logic [2:0]             flag_cnt;
  logic [OUT_WIDTH_A-1:0] sel_data;
  logic [1:0]             sel_tag;
  logic                   sel_carry;

  // Fixed priority Arith > Logic > CMP > Shift; narrow results are zero-extended.
  always_comb begin
    sel_data  = '0;
    sel_tag   = TAG_ARITH;
    sel_carry = 1'b0;
    if (Arith_Flag) begin
      sel_data  = Arith_OUT;
      sel_tag   = TAG_ARITH;
      sel_carry = Carry_OUT;
    end else if (Logic_Flag) begin
      sel_data  = OUT_WIDTH_A'(Logic_OUT);
      sel_tag   = TAG_LOGIC;
    end else if (CMP_Flag) begin
      sel_data  = OUT_WIDTH_A'(CMP_OUT);
      sel_tag   = TAG_CMP;
    end else if (Shift_Flag) begin
      sel_data  = OUT_WIDTH_A'(Shift_OUT);
      sel_tag   = TAG_SHIFT;
    end
  end

  always_comb begin
    flag_cnt = {2'b00, Arith_Flag} + {2'b00, Logic_Flag}
             + {2'b00, CMP_Flag}   + {2'b00, Shift_Flag};
    multi    = (flag_cnt > 3'd1);
    push     = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
    pop      = (count != '0) & RES_READY;
    full     = (count == FULL_CNT);
    // When full, a same-cycle pop frees the slot the write lands in.
    write_en = push & (~full | pop);
    drop     = push & full & ~pop;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ERR_OVF   <= 1'b0;
      ERR_MULTI <= 1'b0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({write_en, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      // A new error in the clearing cycle wins over the clear.
      ERR_OVF   <= (ERR_OVF   & ~CLR_ERR) | drop;
      ERR_MULTI <= (ERR_MULTI & ~CLR_ERR) | multi;
    end
  end

  always_ff @(posedge CLK) begin
    if (write_en) begin
      mem_data[wr_ptr]  <= sel_data;
      mem_tag[wr_ptr]   <= sel_tag;
      mem_carry[wr_ptr] <= sel_carry;
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  always_comb begin
    RES_VALID = (count != '0);
    RES_COUNT = count;
    RES_DATA  = RES_VALID ? mem_data[rd_ptr]  : '0;
    RES_TAG   = RES_VALID ? mem_tag[rd_ptr]   : 2'b00;
    RES_CARRY = RES_VALID ? mem_carry[rd_ptr] : 1'b0;
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: a queue-based reference model
// fed by the driver, checked by an independent head/handshake monitor.
module tb_alu_result_collector;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_OUT;
  logic [15:0] Logic_OUT, CMP_OUT, Shift_OUT;
  logic        Carry_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        RES_READY, CLR_ERR;
  logic        RES_VALID;
  logic [31:0] RES_DATA;
  logic [1:0]  RES_TAG;
  logic        RES_CARRY;
  logic [2:0]  RES_COUNT;
  logic        ERR_OVF, ERR_MULTI;

  alu_result_collector #(.OUT_WIDTH_A(32), .OUT_WIDTH(16), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT),
    .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .RES_READY(RES_READY), .CLR_ERR(CLR_ERR),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_TAG(RES_TAG), .RES_CARRY(RES_CARRY),
    .RES_COUNT(RES_COUNT), .ERR_OVF(ERR_OVF), .ERR_MULTI(ERR_MULTI)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  t;
    logic        c;
  } ent_t;

  ent_t exp_q[$];
  int   mcount = 0;
  bit   e_ovf = 0, e_multi = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; flags = {shift, cmp, logic, arith}.
  task automatic drive(input logic [3:0] flags, input logic [31:0] a, input logic [15:0] l,
                       input logic [15:0] c, input logic [15:0] s, input logic cy,
                       input logic rdy, input logic clr);
    ent_t e;
    bit   pop_m, push_m, full_m, stored;
    @(negedge CLK); #1;
    check("count", {61'd0, RES_COUNT}, 64'(mcount));
    check("err_ovf", {63'd0, ERR_OVF}, {63'd0, e_ovf});
    check("err_multi", {63'd0, ERR_MULTI}, {63'd0, e_multi});
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = flags;
    Arith_OUT = a; Logic_OUT = l; CMP_OUT = c; Shift_OUT = s; Carry_OUT = cy;
    RES_READY = rdy; CLR_ERR = clr;
    if (flags[0])      e = '{a, 2'd0, cy};
    else if (flags[1]) e = '{{16'd0, l}, 2'd1, 1'b0};
    else if (flags[2]) e = '{{16'd0, c}, 2'd2, 1'b0};
    else               e = '{{16'd0, s}, 2'd3, 1'b0};
    pop_m  = (mcount > 0) && rdy;
    push_m = (flags != 4'd0);
    full_m = (mcount == DEPTH);
    stored = push_m && (!full_m || pop_m);
    if (stored) exp_q.push_back(e);
    e_ovf   = (e_ovf && !clr) || (push_m && !stored);
    e_multi = (e_multi && !clr) || ($countones(flags) > 1);
    mcount  = mcount + int'(stored) - int'(pop_m);
  endtask

  task automatic idle(input logic rdy, input logic clr);
    drive(4'd0, 32'd0, 16'd0, 16'd0, 16'd0, 1'b0, rdy, clr);
  endtask

  // Head is compared every cycle it is valid (stability under stall);
  // it is retired only when the handshake completes.
  initial begin
    forever begin
      @(negedge CLK); #3;
      if (!RST && RES_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("head_unexpected", {31'd0, RES_DATA, RES_TAG, RES_CARRY}, 64'hDEAD);
        end else begin
          check("head", {31'd0, RES_DATA, RES_TAG, RES_CARRY},
                {31'd0, exp_q[0].d, exp_q[0].t, exp_q[0].c});
          if (RES_READY) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = 4'd0;
    Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0; Carry_OUT = 1'b0;
    RES_READY = 1'b0; CLR_ERR = 1'b0;
    #3;
    check("rst_outputs", {26'd0, RES_VALID, RES_DATA, RES_TAG, RES_CARRY, RES_COUNT, ERR_OVF, ERR_MULTI}, 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Single arith result with carry
    drive(4'b0001, 32'hFFFF_FFF6, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Zero-extension and ordering
    drive(4'b0010, 32'h0, 16'h00F0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    drive(4'b0100, 32'h0, 16'h0, 16'h0003, 16'h0, 1'b1, 1'b0, 1'b0);
    drive(4'b1000, 32'h0, 16'h0, 16'h0, 16'h8000, 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b1, 1'b0);

    // Overflow: fifth result dropped, then clear
    for (int i = 1; i <= 5; i++) drive(4'b0001, 32'(i), 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    repeat (5) idle(1'b1, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 5; i <= 8; i++) drive(4'b0001, 32'(i), 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 32'd9, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    repeat (6) idle(1'b1, 1'b0);

    // Multi-flag: logic wins over shift
    drive(4'b1010, 32'h0, 16'h0011, 16'h0, 16'h0022, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // Reset between edges with three entries queued
    for (int i = 0; i < 3; i++) drive(4'b0001, 32'hA0 + 32'(i), 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    @(negedge CLK); #1;
    RST = 1'b1;
    #1;
    check("midrst_valid_count", {60'd0, RES_VALID, RES_COUNT}, 64'd0);
    check("midrst_head", {31'd0, RES_DATA, RES_TAG, RES_CARRY}, 64'd0);
    exp_q.delete();
    mcount = 0; e_ovf = 0; e_multi = 0;
    #2;
    RST = 1'b0;
    drive(4'b0001, 32'h55, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] f;
      f[0] = ($urandom_range(0, 9) < 3);
      f[1] = ($urandom_range(0, 9) < 3);
      f[2] = ($urandom_range(0, 9) < 3);
      f[3] = ($urandom_range(0, 9) < 3);
      drive(f, $urandom, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    repeat (DEPTH + 3) idle(1'b1, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of the ALU top level. Each cycle it watches the four unit flags, selects the one active unit result, and tags it with its source unit. It carries the carry bit with the result and queues everything in a small first-word-fall-through FIFO. A consumer drains the FIFO through a valid/ready handshake, so ALU results are never lost while the consumer stalls; overflow and multi-flag conditions are reported through sticky error bits.

## Interface
- OUT_WIDTH_A, 32, width of the arithmetic result and of the stored data word
- OUT_WIDTH, 16, width of the logic/compare/shift results (must be ≤ OUT_WIDTH_A)
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- Arith_OUT  in  OUT_WIDTH_A  signed arithmetic result
- Logic_OUT, CMP_OUT, Shift_OUT  in  OUT_WIDTH each  unit results
- Carry_OUT  in  1  arithmetic carry
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  unit result valid this cycle
- RES_READY  in  1  consumer accepts the head entry
- CLR_ERR  in  1  synchronous clear of the sticky error bits
- RES_VALID  out  1  FIFO non-empty
- RES_DATA  out  OUT_WIDTH_A  head entry data
- RES_TAG  out  2  head entry source: 00 arith, 01 logic, 10 cmp, 11 shift
- RES_CARRY  out  1  head entry carry (0 for non-arith entries)
- RES_COUNT  out  log2(DEPTH)+1  entries held
- ERR_OVF  out  1  sticky: a result was dropped because the FIFO was full
- ERR_MULTI  out  1  sticky: more than one flag was high in the same cycle

## Operation
- Push request = OR of the four flags.
- Select by priority Arith > Logic > CMP > Shift.
- Arith data is stored unchanged. Logic, CMP and Shift data are zero-extended to OUT_WIDTH_A.
- Carry is stored only for the arith tag; it is forced to 0 otherwise.
- Two or more flags high in one cycle: store only the highest-priority result and set ERR_MULTI.
- Pop = RES_VALID & RES_READY. The head entry advances on the pop edge.
- Storage is a DEPTH-entry array with wr_ptr/rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH. A separate count register tracks occupancy.
- Full (count == DEPTH) with a push and no pop: the result is dropped, ERR_OVF is set, and the storage is unchanged.
- Full with push and pop in the same cycle: both happen; count stays DEPTH; no overflow.
- Empty with pop: impossible, because RES_VALID = 0.
- Empty with push: the entry is written and becomes visible next cycle. There is no same-cycle bypass.
- CLR_ERR clears ERR_OVF and ERR_MULTI on the next edge. If a new error condition occurs in the same cycle as CLR_ERR, the set wins.
- RES_DATA, RES_TAG and RES_CARRY are driven from the entry at rd_ptr.
  - They must hold stable while RES_VALID = 1 and RES_READY = 0.
  - They are don't-care while RES_VALID = 0, but must be 0 after reset.

## Timing
- Asserting RST immediately clears wr_ptr, rd_ptr, count, ERR_OVF and ERR_MULTI.
- Reset values of every output: RES_VALID = 0, RES_DATA = 0, RES_TAG = 00, RES_CARRY = 0, RES_COUNT = 0, ERR_OVF = 0, ERR_MULTI = 0.
- Storage contents need not be reset, but the head-entry outputs must read 0 while empty after reset.
- Reset asserted mid-operation discards all queued entries. The first post-reset push lands at index 0.
- Latency: flag high at edge N → RES_VALID high after edge N, i.e. observable in cycle N+1.
- Throughput: one push and one pop per cycle sustained. With RES_READY held high, count never exceeds 1.
- RES_COUNT is registered and updates on the same edge as the push/pop.
- All inputs are sampled on the rising CLK edge. There are no combinational paths from inputs to outputs, other than via registered state.

## Test plan
- Reset and single result:
  - Stimulus: after reset, pulse Arith_Flag for one cycle with Arith_OUT = 32'hFFFF_FFF6 (−10) and Carry_OUT = 1; RES_READY = 0.
  - Required response: next cycle RES_VALID = 1, RES_DATA = FFFF_FFF6, RES_TAG = 00, RES_CARRY = 1, RES_COUNT = 1.
- Zero-extension and order:
  - Stimulus: push Logic 16'h00F0, then CMP 16'h0003, then Shift 16'h8000 on consecutive cycles, then raise RES_READY.
  - Required response: pops in order 0000_00F0/01, 0000_0003/10, 0000_8000/11, each with RES_CARRY = 0.
- Overflow:
  - Stimulus: with RES_READY = 0, push 5 arith results 1..5.
  - Required response: RES_COUNT = 4 and ERR_OVF = 1; draining yields 1, 2, 3, 4.
  - Then assert CLR_ERR for one cycle → ERR_OVF = 0.
- Full with simultaneous push/pop:
  - Stimulus: fill 4 entries, then push value 9 with RES_READY = 1 in the same cycle.
  - Required response: count stays 4, ERR_OVF stays 0, and the last entry popped is 9.
- Multi-flag:
  - Stimulus: Logic_Flag and Shift_Flag high together, with Logic_OUT = 16'h0011 and Shift_OUT = 16'h0022.
  - Required response: one entry is stored, 0000_0011 with tag 01, and ERR_MULTI = 1.
- Reset mid-stream:
  - Stimulus: with 3 entries queued, assert RST between clock edges.
  - Required response: RES_VALID and RES_COUNT drop to 0 immediately without a clock edge.
  - After release, one push appears alone at the head.
